// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage.
// NOP encoding, reset PC default, state encoding and buffer payload.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        misalign;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched {misalign, pc, inst} entries.
// Ports: clk, rst_n (sync low), flush, push/din, pop, head, count.
// flush empties the FIFO; a push in the same cycle becomes the sole entry.
module fetch_buf
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 din,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      if (push) begin
        mem[0] <= din;
        wr_ptr <= nxt('0);
        count  <= CW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem requests, buffered decode feed.
// Ports: clk, rst_n, redirect_*, imem_req_*/imem_addr, imem_resp_*,
// id_valid/id_ready/id_pc/id_inst/id_misalign.
// Macro FETCH_MISALIGN_TRAP_EN: misaligned redirect emits marker + HALT.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_misalign
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_next;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic [CW-1:0] count;
  logic [31:0]   pc;
  logic [31:0]   req_addr;
  logic [31:0]   credit;
  logic          inflight;
  logic          pop;
  logic          push;
  logic          accept;
  logic          bad_redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad_redirect = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign bad_redirect = 1'b0;
`endif

  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready;

  // Slots already claimed after this cycle's pop: buffered + in flight.
  assign credit = 32'(count) + 32'(inflight) - 32'(pop);

  assign imem_req_valid = rst_n & (state == RUN) & ~redirect_valid
                        & (credit < 32'(BUF_DEPTH));
  assign imem_addr      = rst_n ? pc : '0;
  assign accept         = imem_req_valid & imem_req_ready;

  // A response landing in a redirect cycle is wrong-path and dropped.
  assign push = bad_redirect | (imem_resp_valid & ~redirect_valid);

  always_comb begin
    push_data = '{misalign: 1'b0, pc: req_addr, inst: imem_resp_data};
    if (bad_redirect) begin
      push_data = '{misalign: 1'b1, pc: redirect_pc, inst: NOP_INST};
    end
  end

  always_comb begin
    state_next = state;
    if (bad_redirect) begin
      state_next = HALT;
    end else if (redirect_valid) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_addr <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= word_align(redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        pc       <= pc + 32'd4;
        req_addr <= pc;
      end
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign id_pc       = head.pc;
  assign id_inst     = head.inst;
  assign id_misalign = head.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cycle table + random
// traffic against a queue-based fetch/decode model.
module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_misalign;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_stage #(
    .RESET_PC  (32'h0),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_misalign     (id_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: answers every accepted request one cycle later.
  always @(posedge clk) begin
    imem_resp_valid <= rst_n & imem_req_valid & imem_req_ready;
    imem_resp_data  <= imem_addr ^ KEY;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] rpc;
    bit          mr;
    bit          ir;
    bit          req;
    logic [31:0] addr;
    bit          idv;
    logic [31:0] pc;
    logic [31:0] inst;
    bit          mis;
  } vec_t;

  function automatic vec_t mk(bit rd, logic [31:0] rpc, bit mr, bit ir,
                              bit req, logic [31:0] addr, bit idv,
                              logic [31:0] pc);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.mr = mr; v.ir = ir;
    v.req = req; v.addr = addr; v.idv = idv; v.pc = pc;
    v.inst = pc ^ KEY;
    v.mis = 1'b0;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    vec_t        mv;
    logic [31:0] q[$];
    bit          infl;
    logic [31:0] infl_a;
    logic [31:0] fptr;
    int          occ;
    bit          pop_m;
    bit          exp_req;
    int          pops;

    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;

    // Reset release, then 0,4,8 back to back
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h0,   0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h4,   0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h8,   1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'hC,   1, 32'h4));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h10,  1, 32'h8));
    // Decode stall for 5 cycles
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h14,  1, 32'hC));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 32'h14, 1, 32'hC));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h14,  1, 32'hC));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h18,  1, 32'h10));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h1C,  1, 32'h14));
    // Redirect to 0x100 with one buffered, one in flight
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h18));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h104, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h108, 1, 32'h100));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h10C, 1, 32'h104));
    // Memory not ready for 3 cycles
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h110, 1, 32'h108));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h110, 1, 32'h10C));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h110, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h110, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h114, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h118, 1, 32'h110));
    // Redirect near top of address space, PC wraps to 0
    vecs.push_back(mk(1, 32'hFFFF_FFF8, 1, 1, 0, 32'h0, 1, 32'h114));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'hFFFF_FFF8, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h0, 1, 32'hFFFF_FFF8));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h4, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h8, 1, 32'h0));
    // Misaligned redirect target
    vecs.push_back(mk(1, 32'h102, 1, 1, 0, 32'h0, 1, 32'h4));
`ifdef FETCH_MISALIGN_TRAP_EN
    mv = mk(0, 0, 1, 1, 0, 32'h0, 1, 32'h102);
    mv.inst = 32'h0000_0013;
    mv.mis = 1'b1;
    vecs.push_back(mv);
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h200, 1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h200, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h204, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h208, 1, 32'h200));
`else
    mv = mk(0, 0, 1, 1, 1, 32'h100, 0, 0);
    vecs.push_back(mv);
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h104, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h108, 1, 32'h100));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_inst", id_inst, 0);
    chk("rst_id_misalign", 32'(id_misalign), 0);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_imem_addr", imem_addr, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = 1'b1;
      redirect_valid = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      imem_req_ready = vecs[i].mr;
      id_ready = vecs[i].ir;
      #1;
      chk($sformatf("row%0d_req", i), 32'(imem_req_valid),
          32'(vecs[i].req));
      if (vecs[i].req)
        chk($sformatf("row%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("row%0d_idv", i), 32'(id_valid), 32'(vecs[i].idv));
      if (vecs[i].idv) begin
        chk($sformatf("row%0d_pc", i), id_pc, vecs[i].pc);
        chk($sformatf("row%0d_inst", i), id_inst, vecs[i].inst);
        chk($sformatf("row%0d_mis", i), 32'(id_misalign),
            32'(vecs[i].mis));
      end
    end

    // Random traffic against the fetch/decode model
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    infl = 1'b0;
    infl_a = '0;
    fptr = 32'h0;
    pops = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) @(negedge clk);
      rst_n = 1'b1;
      redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      else
        redirect_pc = $urandom & 32'h0000_FFFC;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 2) != 0);
      #1;
      occ = q.size();
      pop_m = (occ > 0) && id_ready;
      exp_req = !redirect_valid &&
                (occ - int'(pop_m) + int'(infl) < DEPTH);
      chk("rnd_req", 32'(imem_req_valid), 32'(exp_req));
      chk("rnd_idv", 32'(id_valid), 32'(occ > 0));
      if (exp_req) chk("rnd_addr", imem_addr, fptr);
      if (occ > 0) begin
        chk("rnd_pc", id_pc, q[0]);
        chk("rnd_inst", id_inst, q[0] ^ KEY);
        chk("rnd_mis", 32'(id_misalign), 0);
      end
      if (pop_m) begin
        void'(q.pop_front());
        pops++;
      end
      if (redirect_valid) begin
        q.delete();
        infl = 1'b0;
        fptr = redirect_pc;
      end else begin
        if (infl) q.push_back(infl_a);
        if (exp_req && imem_req_ready) begin
          infl = 1'b1;
          infl_a = fptr;
          fptr = fptr + 32'd4;
        end else begin
          infl = 1'b0;
        end
      end
    end
    chk("rnd_progress", 32'(pops > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
